lif_neuron_array: RTL and testbench

Parametrised leaky integrate-and-fire neuron array. It succeeds the fixed 128-neuron, 4-bit spike-accumulate datapath with persistent signed membrane state, saturating arithmetic, optional leak, threshold firing, per-neuron refractory counters and valid/ready handshakes. It sits between the spike/weight vector register outputs (S, W buses) and the neuron state/spike writeback path. Each accepted input beat is one neuron timestep.

---
 rtl/lif_neuron_array.sv | 102 ++++++++++
 tb/tb_lif_neuron_array.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/lif_neuron_array.sv
// Leaky integrate-and-fire neuron array: one timestep per accepted beat, all lanes in parallel,
// with saturating membrane state, optional leak, threshold firing and per-lane refractory counters.
module lif_neuron_array #(
  parameter int N_NEURONS  = 128,
  parameter int W_BITS     = 4,
  parameter int V_BITS     = 16,
  parameter int RP_BITS    = 8,
  parameter int LEAK_SHIFT = 4
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [N_NEURONS-1:0]          spk_in,
  input  logic [N_NEURONS*W_BITS-1:0]   weights,
  input  logic signed [V_BITS-1:0]      vth,
  input  logic [RP_BITS-1:0]            rp,
  input  logic                          leak_en,
  input  logic                          clear,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [N_NEURONS-1:0]          spk_out,
  output logic [N_NEURONS*V_BITS-1:0]   vmem_out,
  output logic                          busy
);

  localparam logic signed [V_BITS-1:0] V_MIN = {1'b1, {(V_BITS-1){1'b0}}};
  localparam logic signed [V_BITS-1:0] V_MAX = ~V_MIN;

  logic [N_NEURONS*RP_BITS-1:0] refr_q;
  logic [N_NEURONS*RP_BITS-1:0] refr_nxt;
  logic [N_NEURONS*V_BITS-1:0]  v_nxt;
  logic [N_NEURONS-1:0]         spk_nxt;
  logic                         accept;

  assign in_ready = !clear && (!out_valid || out_ready);
  assign accept   = in_valid && in_ready;
  assign busy     = out_valid || (|refr_q);

  // vmem_out doubles as the persistent membrane state; it only moves on accept or clear.
  for (genvar i = 0; i < N_NEURONS; i++) begin : g_lane
    logic signed [V_BITS-1:0] v_cur;
    logic signed [V_BITS-1:0] v_lk;
    logic signed [V_BITS-1:0] v_sat;
    logic signed [V_BITS-1:0] v_new;
    logic signed [W_BITS-1:0] w_i;
    logic [V_BITS:0]          sum;
    logic [RP_BITS-1:0]       r_cur;
    logic [RP_BITS-1:0]       r_new;
    logic                     s_new;

    assign v_cur = vmem_out[i*V_BITS +: V_BITS];
    assign w_i   = weights[i*W_BITS +: W_BITS];
    assign r_cur = refr_q[i*RP_BITS +: RP_BITS];
    assign v_lk  = leak_en ? v_cur - (v_cur >>> LEAK_SHIFT) : v_cur;
    // One guard bit so overflow is visible as a mismatch of the top two bits.
    assign sum   = {v_lk[V_BITS-1], v_lk}
                 + (spk_in[i] ? {{(V_BITS+1-W_BITS){w_i[W_BITS-1]}}, w_i} : '0);

    always_comb begin
      v_sat = sum[V_BITS-1:0];
      if (sum[V_BITS] != sum[V_BITS-1]) v_sat = sum[V_BITS] ? V_MIN : V_MAX;
      v_new = v_sat;
      r_new = '0;
      s_new = 1'b0;
      if (r_cur != '0) begin
        r_new = r_cur - RP_BITS'(1);
        v_new = '0;
      end else if (v_sat >= vth) begin
        s_new = 1'b1;
        v_new = '0;
        r_new = rp;
      end
    end

    assign v_nxt[i*V_BITS +: V_BITS]     = v_new;
    assign refr_nxt[i*RP_BITS +: RP_BITS] = r_new;
    assign spk_nxt[i]                     = s_new;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vmem_out  <= '0;
      refr_q    <= '0;
      spk_out   <= '0;
      out_valid <= 1'b0;
    end else if (clear) begin
      vmem_out  <= '0;
      refr_q    <= '0;
      spk_out   <= '0;
      out_valid <= 1'b0;
    end else if (accept) begin
      vmem_out  <= v_nxt;
      refr_q    <= refr_nxt;
      spk_out   <= spk_nxt;
      out_valid <= 1'b1;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_lif_neuron_array.sv
// Directed bench for lif_neuron_array using a small 4-lane, 6-bit membrane configuration.
module tb_lif_neuron_array;
  localparam int N  = 4;
  localparam int WB = 4;
  localparam int VB = 6;
  localparam int RB = 8;
  localparam int LS = 2;

  logic              clk = 1'b0;
  logic              reset;
  logic              in_valid;
  logic              in_ready;
  logic [N-1:0]      spk_in;
  logic [N*WB-1:0]   weights;
  logic signed [VB-1:0] vth;
  logic [RB-1:0]     rp;
  logic              leak_en;
  logic              clear;
  logic              out_valid;
  logic              out_ready;
  logic [N-1:0]      spk_out;
  logic [N*VB-1:0]   vmem_out;
  logic              busy;

  int checks = 0;
  int errors = 0;

  lif_neuron_array #(.N_NEURONS(N), .W_BITS(WB), .V_BITS(VB), .RP_BITS(RB), .LEAK_SHIFT(LS)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready), .spk_in(spk_in),
    .weights(weights), .vth(vth), .rp(rp), .leak_en(leak_en), .clear(clear),
    .out_valid(out_valid), .out_ready(out_ready), .spk_out(spk_out), .vmem_out(vmem_out),
    .busy(busy)
  );

  always #5 clk = ~clk;

  function automatic int lane_v(int l);
    logic signed [VB-1:0] t;
    t = vmem_out[l*VB +: VB];
    return int'(t);
  endfunction

  function automatic logic [N*WB-1:0] pack_w(int w0, int w1, int w2, int w3);
    return {WB'(w3), WB'(w2), WB'(w1), WB'(w0)};
  endfunction

  task automatic check(string tag, int obs, int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic beat(logic [N-1:0] s, logic [N*WB-1:0] w, logic lk);
    spk_in   = s;
    weights  = w;
    leak_en  = lk;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic idle_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic do_clear();
    clear = 1'b1;
    @(posedge clk);
    #1;
    clear = 1'b0;
  endtask

  initial begin
    reset = 1'b1; in_valid = 1'b0; spk_in = '0; weights = '0; vth = 6'sd20; rp = 8'd2;
    leak_en = 1'b0; clear = 1'b0; out_ready = 1'b1;
    #12;
    check("rst_out_valid", out_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_vmem", int'(vmem_out), 0);
    check("rst_spk", int'(spk_out), 0);
    reset = 1'b0;
    #1;
    check("rst_in_ready", in_ready, 1);

    // integrate and fire, then two refractory beats
    beat(4'b0001, pack_w(7, 0, 0, 0), 1'b0);
    check("if_v0_b1", lane_v(0), 7);
    check("if_ov_b1", out_valid, 1);
    beat(4'b0001, pack_w(7, 0, 0, 0), 1'b0);
    check("if_v0_b2", lane_v(0), 14);
    beat(4'b0001, pack_w(7, 0, 0, 0), 1'b0);
    check("if_spk_b3", int'(spk_out), 1);
    check("if_v0_b3", lane_v(0), 0);
    beat(4'b0001, pack_w(7, 0, 0, 0), 1'b0);
    check("if_spk_r1", int'(spk_out), 0);
    check("if_v0_r1", lane_v(0), 0);
    beat(4'b0001, pack_w(7, 0, 0, 0), 1'b0);
    check("if_v0_r2", lane_v(0), 0);
    beat(4'b0001, pack_w(7, 0, 0, 0), 1'b0);
    check("if_v0_b6", lane_v(0), 7);
    idle_cycle();
    check("drain_ov", out_valid, 0);
    check("drain_busy", busy, 0);

    // lower saturation on lane3
    beat(4'b1000, pack_w(0, 0, 0, -8), 1'b0);
    check("sat_v3_1", lane_v(3), -8);
    beat(4'b1000, pack_w(0, 0, 0, -8), 1'b0);
    beat(4'b1000, pack_w(0, 0, 0, -8), 1'b0);
    check("sat_v3_3", lane_v(3), -24);
    beat(4'b1000, pack_w(0, 0, 0, -8), 1'b0);
    check("sat_v3_4", lane_v(3), -32);
    beat(4'b1000, pack_w(0, 0, 0, -8), 1'b0);
    check("sat_v3_5", lane_v(3), -32);
    check("sat_v0_hold", lane_v(0), 7);

    // upper saturation: 28 + 7 clamps to 31 and meets vth=31
    do_clear();
    check("clr_vmem", int'(vmem_out), 0);
    vth = 6'sd31;
    for (int k = 0; k < 4; k++) beat(4'b0010, pack_w(0, 7, 0, 0), 1'b0);
    check("usat_v1_28", lane_v(1), 28);
    beat(4'b0010, pack_w(0, 7, 0, 0), 1'b0);
    check("usat_spk", int'(spk_out), 2);
    check("usat_busy", busy, 1);

    // clear while refractory, with in_valid high
    spk_in = 4'b0010; weights = pack_w(0, 5, 0, 0); in_valid = 1'b1; clear = 1'b1;
    #1;
    check("clr_in_ready", in_ready, 0);
    @(posedge clk);
    #1;
    clear = 1'b0; in_valid = 1'b0;
    check("clr_ov", out_valid, 0);
    check("clr_busy", busy, 0);
    check("clr_spk", int'(spk_out), 0);
    beat(4'b0010, pack_w(0, 5, 0, 0), 1'b0);
    check("clr_post_v1", lane_v(1), 5);

    // leak
    do_clear();
    beat(4'b0110, pack_w(0, 7, -8, 0), 1'b0);
    beat(4'b0110, pack_w(0, 7, -8, 0), 1'b0);
    beat(4'b0010, pack_w(0, 2, 0, 0), 1'b0);
    check("lk_v1_16", lane_v(1), 16);
    check("lk_v2_m16", lane_v(2), -16);
    beat(4'b0000, pack_w(0, 7, 7, 7), 1'b1);
    check("lk_v1_12", lane_v(1), 12);
    check("lk_v2_m12", lane_v(2), -12);
    beat(4'b0000, '0, 1'b1);
    check("lk_v1_9", lane_v(1), 9);
    check("lk_v2_m9", lane_v(2), -9);
    beat(4'b0000, '0, 1'b1);
    check("lk_v1_7", lane_v(1), 7);
    check("lk_v2_m6", lane_v(2), -6);

    // backpressure
    idle_cycle();
    check("bp_drained", out_valid, 0);
    out_ready = 1'b0;
    spk_in = 4'b0010; weights = pack_w(0, 1, 0, 0); leak_en = 1'b0; in_valid = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(posedge clk);
      #1;
    end
    check("bp_in_ready", in_ready, 0);
    check("bp_ov", out_valid, 1);
    check("bp_v1_once", lane_v(1), 8);
    out_ready = 1'b1;
    #1;
    check("bp_ready_pass", in_ready, 1);
    for (int k = 0; k < 3; k++) begin
      @(posedge clk);
      #1;
      check("bp_stream_v1", lane_v(1), 9 + k);
      check("bp_stream_ov", out_valid, 1);
    end
    in_valid = 1'b0;

    // async reset between edges with out_valid high
    #3;
    reset = 1'b1;
    #1;
    check("ar_ov", out_valid, 0);
    check("ar_vmem", int'(vmem_out), 0);
    check("ar_spk", int'(spk_out), 0);
    #2;
    reset = 1'b0;
    beat(4'b0001, pack_w(5, 0, 0, 0), 1'b0);
    check("ar_post_v0", lane_v(0), 5);
    check("ar_post_v1", lane_v(1), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
